// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan sequencer: select width, word size,
// scan start indices and the FSM state encoding.
package mux_scan_pkg;

    localparam int SEL_W = 3;
    localparam int NBITS = 8;

    localparam logic [SEL_W-1:0] SEL_FIRST_FWD = 3'd0;
    localparam logic [SEL_W-1:0] SEL_FIRST_REV = 3'd7;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SCAN = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/mux_scan_ctrl_sel.sv
// 3-bit up/down select counter with synchronous load; at_end flags the final
// index in the current counting direction.
module sel_counter3
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [SEL_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [SEL_W-1:0] q_o,
    output logic             at_end_o
);

    logic [SEL_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (en_i) begin
            q_d = dir_i ? q_q - 3'd1 : q_q + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o      = q_q;
    assign at_end_o = dir_i ? (q_q == 3'd0) : (q_q == 3'd7);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Parallel-to-serial sequencer feeding an 8:1 bit-select mux: holds the word
// on w_o and steps s_o through all positions, one per downstream handshake.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter logic REVERSE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [NBITS-1:0] din_i,
    output logic             in_ready_o,
    output logic [0:NBITS-1] w_o,
    output logic [SEL_W-1:0] s_o,
    output logic             bit_valid_o,
    input  logic             bit_ready_i,
    output logic             last_o,
    output logic             done_o
);

    state_t           state_q, state_d;
    logic [0:NBITS-1] w_q, w_d;
    logic             accept;
    logic             at_end;
    logic             sel_en;

    assign accept = in_valid_i && (state_q == IDLE);
    assign sel_en = (state_q == SCAN) && bit_ready_i && !at_end;

    sel_counter3 u_sel (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (REVERSE ? SEL_FIRST_REV : SEL_FIRST_FWD),
        .en_i       (sel_en),
        .dir_i      (REVERSE),
        .q_o        (s_o),
        .at_end_o   (at_end)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = SCAN;
                    // w is declared [0:7]; copy per bit so w[i] follows din[i]
                    for (int i = 0; i < NBITS; i++) begin
                        w_d[i] = din_i[i];
                    end
                end
            end
            SCAN: begin
                if (bit_ready_i && at_end) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the word register is a handful of flops, not a memory, so it is
    // reset together with the state to give a known bus after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
        end
    end

    assign w_o         = w_q;
    assign in_ready_o  = (state_q == IDLE);
    assign bit_valid_o = (state_q == SCAN);
    assign last_o      = (state_q == SCAN) && at_end;
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: drivers push expected bit/done events,
// a negedge monitor pops and compares them as the DUTs present output.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, bit_ready, use_rev;
    logic [7:0] din;
    logic       in_valid_f, in_valid_r;

    logic       in_ready_f, bv_f, last_f, done_f;
    logic [0:7] w_f;
    logic [2:0] s_f;
    logic       in_ready_r, bv_r, last_r, done_r;
    logic [0:7] w_r;
    logic [2:0] s_r;

    assign in_valid_f = in_valid & ~use_rev;
    assign in_valid_r = in_valid &  use_rev;

    mux_scan_ctrl #(.REVERSE(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_f), .din_i(din),
        .in_ready_o(in_ready_f), .w_o(w_f), .s_o(s_f), .bit_valid_o(bv_f),
        .bit_ready_i(bit_ready), .last_o(last_f), .done_o(done_f)
    );

    mux_scan_ctrl #(.REVERSE(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_r), .din_i(din),
        .in_ready_o(in_ready_r), .w_o(w_r), .s_o(s_r), .bit_valid_o(bv_r),
        .bit_ready_i(bit_ready), .last_o(last_r), .done_o(done_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] s;
        logic       b;
        logic       last;
        logic [7:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   edge_cnt = 0;
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [7:0] flat(input logic [0:7] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle c is the interval following edge c-1; bits start in cycle k+1.
    task automatic push(input logic [7:0] word, input int k, input logic rev,
                        input int nbits, input int st_idx, input int st_len,
                        input logic with_done);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.s    = rev ? 3'(7 - i) : 3'(i);
            e.cyc  = k + 1 + i + ((i >= st_idx) ? st_len : 0);
            e.b    = word[e.s];
            e.last = (i == 7);
            e.word = word;
            exp_q.push_back(e);
        end
        if (with_done) done_q.push_back(k + 9 + st_len);
    endtask

    task automatic accept(input logic [7:0] d, output int k);
        in_valid = 1'b1;
        din      = d;
        tick();
        k        = edge_cnt;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [0:7] cw;
        logic [2:0] cs;
        logic       cbv, clast, cdone;
        int         c;
        exp_t       e;
        if (mon_en) begin
            cw    = use_rev ? w_r    : w_f;
            cs    = use_rev ? s_r    : s_f;
            cbv   = use_rev ? bv_r   : bv_f;
            clast = use_rev ? last_r : last_f;
            cdone = use_rev ? done_r : done_f;
            c     = edge_cnt + 1;
            if (exp_q.size() == 0) begin
                check("bit_valid_idle", 32'(cbv), 32'd0);
            end else if (cbv) begin
                e = exp_q[0];
                check("sel", 32'(cs), 32'(e.s));
                check("last", 32'(clast), 32'(e.last));
                check("word_held", 32'(flat(cw)), 32'(e.word));
                if (bit_ready) begin
                    void'(exp_q.pop_front());
                    check("bit_cycle", 32'(c), 32'(e.cyc));
                    check("serial_bit", 32'(cw[cs]), 32'(e.b));
                end
            end
            if (done_q.size() == 0) begin
                check("done_idle", 32'(cdone), 32'd0);
            end else if (cdone) begin
                check("done_cycle", 32'(c), 32'(done_q.pop_front()));
            end
        end
    end

    initial begin
        int k, k2;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        din       = 8'hFF;
        bit_ready = 1'b1;
        use_rev   = 1'b0;

        // Reset held two cycles with a word offered: nothing is accepted
        tick();
        mon_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            check("rst_w", 32'(flat(w_f)), 32'h00);
            check("rst_s", 32'(s_f), 32'd0);
            check("rst_in_ready", 32'(in_ready_f), 32'd1);
            check("rst_bit_valid", 32'(bv_f), 32'd0);
            check("rst_last", 32'(last_f), 32'd0);
            check("rst_done", 32'(done_f), 32'd0);
            check("rst_s_rev", 32'(s_r), 32'd0);
            if (r == 0) tick();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();

        // Forward scan, no backpressure
        accept(8'b1011_0010, k);
        push(8'b1011_0010, k, 1'b0, 8, 8, 0, 1'b1);
        repeat (10) tick();

        // Forward scan, bit_ready low for 3 cycles while s = 4
        accept(8'b1011_0010, k);
        push(8'b1011_0010, k, 1'b0, 8, 4, 3, 1'b1);
        repeat (4) tick();
        bit_ready = 1'b0;
        repeat (3) tick();
        bit_ready = 1'b1;
        repeat (6) tick();

        // Reverse scan with ignored words offered during SCAN and DONE
        use_rev = 1'b1;
        accept(8'h81, k);
        push(8'h81, k, 1'b1, 8, 8, 0, 1'b1);
        repeat (2) tick();
        in_valid = 1'b1;
        din      = 8'h55;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("rev_w_kept", 32'(flat(w_r)), 32'h81);
        check("rev_no_wrap", 32'(s_r), 32'd0);
        check("rev_in_ready", 32'(in_ready_r), 32'd1);
        tick();
        use_rev = 1'b0;

        // Reset asserted while s = 5: word abandoned, no done pulse
        accept(8'h3C, k);
        push(8'h3C, k, 1'b0, 6, 8, 0, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(in_ready_f), 32'd1);
        check("midrst_bit_valid", 32'(bv_f), 32'd0);
        check("midrst_s", 32'(s_f), 32'd0);
        check("midrst_w", 32'(flat(w_f)), 32'h00);
        tick();

        // Back-to-back: in_valid held high, second accept 10 edges later
        accept(8'hA5, k);
        push(8'hA5, k, 1'b0, 8, 8, 0, 1'b1);
        in_valid = 1'b1;
        din      = 8'h5A;
        repeat (10) tick();
        k2       = edge_cnt;
        in_valid = 1'b0;
        push(8'h5A, k2, 1'b0, 8, 8, 0, 1'b1);
        repeat (11) tick();

        check("bits_outstanding", 32'(exp_q.size()), 32'd0);
        check("done_outstanding", 32'(done_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the team's 8:1 bit-select multiplexer. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data bus. It then steps the 3-bit select through all eight positions, one bit per downstream handshake. The result is a parallel-to-serial path: the mux output is the serial bit, qualified by `bit_valid`.

## Interface
- `REVERSE`, default 0: 0 scans select 0→7; 1 scans 7→0.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: upstream offers a word on `din`.
- `din` input 8: word to serialize; `din[0]` maps to mux input 0.
- `in_ready` output 1: block accepts a word this cycle.
- `w` output 8 (indexed [0:7]): held word, driven to mux data inputs.
- `s` output 3: mux select.
- `bit_valid` output 1: mux output is a valid serial bit this cycle.
- `bit_ready` input 1: downstream consumes the current bit.
- `last` output 1: current bit is the final bit of the word.
- `done` output 1: one-cycle pulse after the final bit is consumed.

## Operation
- States:
  - IDLE: `in_ready=1`, `bit_valid=0`.
  - SCAN: `bit_valid=1`.
  - DONE: one cycle, `done=1`, `in_ready=0`.
- Transitions:
  - IDLE→SCAN on `in_valid && in_ready`. Latch `din` into `w`. Load `s` = 0 (REVERSE=0) or 7 (REVERSE=1).
  - SCAN, bit handshake (`bit_valid && bit_ready`), not last: `s` += 1 (or −= 1 for REVERSE=1).
  - SCAN, bit handshake with `last=1`: go to DONE. `s` holds its last value.
  - SCAN, `bit_ready=0`: hold `s` and `w`. No bit is lost or repeated.
  - DONE→IDLE unconditionally.
- `last` = SCAN && `s` == 7 (REVERSE=0) or `s` == 0 (REVERSE=1).
- `s` never wraps inside a word. No increment past the final index in SCAN.
- `w` changes only on an input handshake. It is held through SCAN, DONE and IDLE until the next accept.
- `in_valid` while not in IDLE is ignored. Upstream must hold `din` until `in_ready`.
- `in_ready`, `bit_valid`, `last` and `done` are decoded from the state register and `s`. They do not depend combinationally on `in_valid` or `bit_ready`.

## Timing
- Reset (`rst_n=0` at an edge) applies from the next cycle:
  - State IDLE.
  - `w`=8'h00, `s`=3'd0.
  - `in_ready`=1, `bit_valid`=0, `last`=0, `done`=0.
- Reset mid-SCAN: the word is abandoned and reset values apply next cycle. No `done` pulse.
- Accept at edge k: `bit_valid=1` with the first index from cycle k+1.
- With `bit_ready` held high:
  - bits occupy cycles k+1..k+8.
  - `done` is high in cycle k+9.
  - `in_ready` is high from cycle k+10.
  - Earliest next accept is edge k+10, giving throughput of one word per 10 cycles.
- Each low cycle of `bit_ready` in SCAN extends every later timing by one cycle.
- Reset has priority over all handshakes in the same cycle.

## Structure
- Shared package `mux_scan_pkg`:
  - state enum (`IDLE`, `SCAN`, `DONE`, 2 bits);
  - localparams `SEL_W`=3 and `NBITS`=8;
  - localparams `SEL_FIRST_FWD`=0 and `SEL_FIRST_REV`=7.
- One natural sub-module, `sel_counter3`. It is a 3-bit up/down counter with sync active-low reset, `load`, `load_val`, `en` and `dir`, and outputs `q` and `at_end`. The top level holds only the FSM and the word register.
- The top level is instanced beside the 8:1 mux, with `w` and `s` wired straight across.

## Test plan
- Reset: drive `rst_n=0` for 2 cycles with `in_valid=1` and `din`=8'hFF. Required: `w`=0, `s`=0, `in_ready`=1, `bit_valid`=0 and no accept.
- Forward scan, REVERSE=0: accept `din`=8'b1011_0010 with `bit_ready`=1 throughout.
  - `s` reads 0..7 on cycles k+1..k+8.
  - The mux output sequence is `din[0]`..`din[7]` = 0,1,0,0,1,1,0,1.
  - `last` is high only at k+8; `done` is high only at k+9.
- Backpressure: in the same scan, hold `bit_ready`=0 for 3 cycles while `s`=4.
  - Required: `s` stays at 4 and `w` is unchanged.
  - `done` shifts to k+12.
- Reverse scan, REVERSE=1: accept `din`=8'h81.
  - `s` reads 7..0.
  - `last` is high when `s`=0.
  - No wrap to 7 after the final bit.
- Ignored input: pulse `in_valid` with `din`=8'h55 during SCAN and during DONE. Required: `w` keeps the original word and the scan is undisturbed.
- Mid-scan reset and back-to-back words:
  - Assert `rst_n=0` at `s`=5. Required: IDLE next cycle and no `done`.
  - Then hold `in_valid` high with two words. Required: the accepts occur 10 cycles apart.
